// File: rtl/wb_stage_reg_if.sv
// MEM/WB boundary bus: memory-stage operands in, register-file write port,
// forwarding bus and stage status out.
interface wb_stage_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
);
  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  logic                  in_valid;
  logic                  in_reg_wen;
  logic [REG_ADDR_W-1:0] in_reg_addr;
  logic [1:0]            in_wb_sel;
  logic [1:0]            in_load_size;
  logic                  in_load_signed;
  logic [OFF_W-1:0]      in_addr_lo;
  logic [DATA_W-1:0]     in_alu_result;
  logic [DATA_W-1:0]     in_mem_rdata;
  logic [DATA_W-1:0]     in_link_pc;
  logic [DATA_W-1:0]     in_aux;

  logic                  rf_wen;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0]     fwd_data;
  logic                  wb_valid;
  logic                  misalign_err;
  logic [CNT_W-1:0]      retired_cnt;

  modport master (
    output in_valid, in_reg_wen, in_reg_addr, in_wb_sel, in_load_size, in_load_signed,
           in_addr_lo, in_alu_result, in_mem_rdata, in_link_pc, in_aux,
    input  rf_wen, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data, wb_valid,
           misalign_err, retired_cnt
  );

  modport slave (
    input  in_valid, in_reg_wen, in_reg_addr, in_wb_sel, in_load_size, in_load_signed,
           in_addr_lo, in_alu_result, in_mem_rdata, in_link_pc, in_aux,
    output rf_wen, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data, wb_valid,
           misalign_err, retired_cnt
  );
endinterface

// File: rtl/wb_stage_reg.sv
// Registered MIPS write-back stage: MEM/WB register with stall/flush, source select,
// sub-word load extraction, register-file/forwarding drive and retired-instruction counter.
module wb_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  wb_stage_reg_if.slave    bus
);
  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  localparam logic [1:0] SelAlu  = 2'd0;
  localparam logic [1:0] SelMem  = 2'd1;
  localparam logic [1:0] SelLink = 2'd2;

  logic                  valid_q, valid_d;
  logic                  reg_wen_q, reg_wen_d;
  logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [1:0]            wb_sel_q, wb_sel_d;
  logic [1:0]            load_size_q, load_size_d;
  logic                  load_signed_q, load_signed_d;
  logic [OFF_W-1:0]      addr_lo_q, addr_lo_d;
  logic [DATA_W-1:0]     alu_q, alu_d, mem_q, mem_d, link_q, link_d, aux_q, aux_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  commit;
  logic                  misalign;
  logic [DATA_W-1:0]     shifted, lane_mask, load_val, sel_val;
  logic [7:0]            nbits;
  logic                  sign_bit;
  logic [OFF_W-1:0]      size_mask;

  always_comb begin
    valid_d       = valid_q;
    reg_wen_d     = reg_wen_q;
    reg_addr_d    = reg_addr_q;
    wb_sel_d      = wb_sel_q;
    load_size_d   = load_size_q;
    load_signed_d = load_signed_q;
    addr_lo_d     = addr_lo_q;
    alu_d         = alu_q;
    mem_d         = mem_q;
    link_d        = link_q;
    aux_d         = aux_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      valid_d       = bus.in_valid;
      reg_wen_d     = bus.in_reg_wen;
      reg_addr_d    = bus.in_reg_addr;
      wb_sel_d      = bus.in_wb_sel;
      load_size_d   = bus.in_load_size;
      load_signed_d = bus.in_load_signed;
      addr_lo_d     = bus.in_addr_lo;
      alu_d         = bus.in_alu_result;
      mem_d         = bus.in_mem_rdata;
      link_d        = bus.in_link_pc;
      aux_d         = bus.in_aux;
    end
  end

  // Commit is independent of flush: a flushed-but-unstalled instruction retires this cycle.
  assign commit = valid_q & ~stall_i;
  assign cnt_d  = cnt_q + CNT_W'(commit);

  always_comb begin
    shifted   = mem_q >> {addr_lo_q, 3'b000};
    nbits     = 8'd8 << load_size_q;
    lane_mask = '1;
    if (32'(nbits) < DATA_W) lane_mask = {DATA_W{1'b1}} >> (DATA_W - 32'(nbits));
    unique case (load_size_q)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_W-1];
    endcase
    load_val = shifted & lane_mask;
    if (load_signed_q && sign_bit) load_val = load_val | ~lane_mask;

    size_mask = OFF_W'((8'd1 << load_size_q) - 8'd1);
    misalign  = valid_q && (wb_sel_q == SelMem) &&
                (((load_size_q == 2'd3) && (DATA_W == 32)) || ((addr_lo_q & size_mask) != '0));

    unique case (wb_sel_q)
      SelAlu:  sel_val = alu_q;
      SelMem:  sel_val = load_val;
      SelLink: sel_val = link_q;
      default: sel_val = aux_q;
    endcase
  end

  always_comb begin
    bus.wb_valid     = valid_q;
    bus.misalign_err = misalign;
    bus.rf_wen       = commit & reg_wen_q & (reg_addr_q != '0) & ~misalign;
    bus.rf_waddr     = valid_q ? reg_addr_q : '0;
    bus.rf_wdata     = (valid_q && !misalign) ? sel_val : '0;
    bus.fwd_valid    = bus.rf_wen;
    bus.fwd_addr     = bus.rf_waddr;
    bus.fwd_data     = bus.rf_wdata;
    bus.retired_cnt  = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      reg_wen_q     <= 1'b0;
      reg_addr_q    <= '0;
      wb_sel_q      <= '0;
      load_size_q   <= '0;
      load_signed_q <= 1'b0;
      addr_lo_q     <= '0;
      alu_q         <= '0;
      mem_q         <= '0;
      link_q        <= '0;
      aux_q         <= '0;
      cnt_q         <= '0;
    end else begin
      valid_q       <= valid_d;
      reg_wen_q     <= reg_wen_d;
      reg_addr_q    <= reg_addr_d;
      wb_sel_q      <= wb_sel_d;
      load_size_q   <= load_size_d;
      load_signed_q <= load_signed_d;
      addr_lo_q     <= addr_lo_d;
      alu_q         <= alu_d;
      mem_q         <= mem_d;
      link_q        <= link_d;
      aux_q         <= aux_d;
      cnt_q         <= cnt_d;
    end
  end
endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed bench for wb_stage_reg (DATA_W=32, CNT_W=4 so counter wrap is reachable).
module tb_wb_stage_reg;
  logic clk = 1'b0;
  logic rst, stall_i, flush_i;
  int   n_checks = 0;
  int   n_errors = 0;

  wb_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) bus ();

  wb_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wen, input logic [4:0] addr,
                       input logic [1:0] sel, input logic [1:0] size, input logic sgn,
                       input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] mem);
    bus.in_valid       = v;
    bus.in_reg_wen     = wen;
    bus.in_reg_addr    = addr;
    bus.in_wb_sel      = sel;
    bus.in_load_size   = size;
    bus.in_load_signed = sgn;
    bus.in_addr_lo     = lo;
    bus.in_alu_result  = alu;
    bus.in_mem_rdata   = mem;
  endtask

  task automatic chk_out(input string tag, input logic wen, input logic [4:0] addr,
                         input logic [31:0] data);
    chk({tag, ".rf_wen"}, 64'(bus.rf_wen), 64'(wen));
    chk({tag, ".rf_waddr"}, 64'(bus.rf_waddr), 64'(addr));
    chk({tag, ".rf_wdata"}, 64'(bus.rf_wdata), 64'(data));
    chk({tag, ".fwd_valid"}, 64'(bus.fwd_valid), 64'(wen));
    chk({tag, ".fwd_addr"}, 64'(bus.fwd_addr), 64'(addr));
    chk({tag, ".fwd_data"}, 64'(bus.fwd_data), 64'(data));
  endtask

  task automatic chk_reset(input string tag);
    chk_out(tag, 1'b0, 5'd0, 32'd0);
    chk({tag, ".wb_valid"}, 64'(bus.wb_valid), 64'd0);
    chk({tag, ".misalign"}, 64'(bus.misalign_err), 64'd0);
    chk({tag, ".cnt"}, 64'(bus.retired_cnt), 64'd0);
  endtask

  localparam logic [31:0] MemWord = 32'h80FF_7F01;

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    bus.in_link_pc = 32'hAAAA_0000;
    bus.in_aux     = 32'h0000_5555;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    chk_reset("rst");

    // ALU op
    drive(1, 1, 5'd8, 2'd0, 2'd2, 0, 0, 32'h1234_5678, 0);
    tick();
    chk_out("alu", 1, 5'd8, 32'h1234_5678);
    chk("alu.wb_valid", 64'(bus.wb_valid), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("alu.cnt", 64'(bus.retired_cnt), 64'd1);
    chk("bubble.wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("bubble.rf_wen", 64'(bus.rf_wen), 64'd0);

    // Back-to-back loads and other sources
    drive(1, 1, 5'd3, 2'd1, 2'd0, 1, 2'd3, 0, MemWord);
    tick();
    chk_out("lb_s3", 1, 5'd3, 32'hFFFF_FF80);
    drive(1, 1, 5'd4, 2'd1, 2'd0, 0, 2'd1, 0, MemWord);
    tick();
    chk_out("lbu_1", 1, 5'd4, 32'h0000_007F);
    drive(1, 1, 5'd5, 2'd1, 2'd1, 1, 2'd2, 0, MemWord);
    tick();
    chk_out("lh_s2", 1, 5'd5, 32'hFFFF_80FF);
    drive(1, 1, 5'd6, 2'd1, 2'd1, 1, 2'd1, 0, MemWord);
    tick();
    chk_out("lh_mis", 0, 5'd6, 32'd0);
    chk("lh_mis.err", 64'(bus.misalign_err), 64'd1);
    drive(1, 1, 5'd0, 2'd0, 2'd2, 0, 0, 32'h0000_DEAD, 0);
    tick();
    chk_out("r0", 0, 5'd0, 32'h0000_DEAD);
    drive(1, 1, 5'd31, 2'd2, 2'd2, 0, 0, 0, 0);
    tick();
    chk_out("link", 1, 5'd31, 32'hAAAA_0000);
    // AUX with an odd offset must not flag misalignment
    drive(1, 1, 5'd9, 2'd3, 2'd1, 0, 2'd1, 0, 0);
    tick();
    chk_out("aux", 1, 5'd9, 32'h0000_5555);
    chk("aux.err", 64'(bus.misalign_err), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("seq.cnt", 64'(bus.retired_cnt), 64'd8);

    // Stall 3 cycles: a single commit in the first unstalled cycle
    drive(1, 1, 5'd5, 2'd0, 2'd2, 0, 0, 32'h77, 0);
    tick();
    stall_i = 1'b1;
    drive(1, 1, 5'd7, 2'd0, 2'd2, 0, 0, 32'h99, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d.rf_wen", i), 64'(bus.rf_wen), 64'd0);
      chk($sformatf("stall%0d.waddr", i), 64'(bus.rf_waddr), 64'd5);
      if (i < 2) tick();
    end
    stall_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("unstall", 1, 5'd5, 32'h77);
    chk("unstall.cnt", 64'(bus.retired_cnt), 64'd8);
    tick();
    chk("post_stall.rf_wen", 64'(bus.rf_wen), 64'd0);
    chk("post_stall.cnt", 64'(bus.retired_cnt), 64'd9);

    // Flush during stall: held instruction discarded
    drive(1, 1, 5'd6, 2'd0, 2'd2, 0, 0, 32'h66, 0);
    tick();
    stall_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fl_stall.rf_wen", 64'(bus.rf_wen), 64'd0);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; stall_i = 1'b0;
    #1;
    chk("fl.wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("fl.rf_wen", 64'(bus.rf_wen), 64'd0);
    tick();
    chk("fl.cnt", 64'(bus.retired_cnt), 64'd9);

    // Flush with incoming valid drops it
    drive(1, 1, 5'd2, 2'd0, 2'd2, 0, 0, 32'h22, 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("fl_in.wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("fl_in.rf_wen", 64'(bus.rf_wen), 64'd0);

    // 17 commits on a 4-bit counter wrap to 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrap.start", 64'(bus.retired_cnt), 64'd0);
    drive(1, 1, 5'd1, 2'd0, 2'd2, 0, 0, 32'h1, 0);
    for (int i = 0; i < 17; i++) tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("wrap.cnt", 64'(bus.retired_cnt), 64'd1);

    // Reset during stall and flush wins
    drive(1, 1, 5'd12, 2'd0, 2'd2, 0, 0, 32'hABCD, 0);
    tick();
    chk_out("pre_rst", 1, 5'd12, 32'hABCD);
    stall_i = 1'b1; flush_i = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_reset("mid_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/wb_stage_reg.md
# wb_stage_reg

Parametrised write-back stage for the pipelined MIPS core, built as the successor to the combinational write-back mux. It registers the MEM/WB pipeline boundary itself and supports stall, flush and a valid bit. It selects among four result sources and extracts and extends sub-word load data. It drives both the register-file write port and the forwarding bus, and keeps a retired-instruction counter. Position: between the memory stage and the register file / forwarding unit.

## Interface

Parameters:
- DATA_W, 32, datapath width; power of two, 32 or 64
- REG_ADDR_W, 5, register-file address width
- CNT_W, 32, retired-instruction counter width
- OFF_W, derived $clog2(DATA_W/8), byte-offset width (local)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  hold stage contents; suppress commit
- flush_i  in  1  load bubble into stage
- in_valid  in  1  incoming instruction valid
- in_reg_wen  in  1  instruction writes a register
- in_reg_addr  in  REG_ADDR_W  destination register
- in_wb_sel  in  2  source: 0 ALU, 1 MEM, 2 LINK, 3 AUX
- in_load_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64)
- in_load_signed  in  1  sign-extend loaded value
- in_addr_lo  in  OFF_W  low bits of load address
- in_alu_result, in_mem_rdata, in_link_pc, in_aux  in  DATA_W each  source operands
- rf_wen  out  1  register-file write enable
- rf_waddr  out  REG_ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- fwd_valid  out  1  forwarding bus valid (equals rf_wen)
- fwd_addr  out  REG_ADDR_W  equals rf_waddr
- fwd_data  out  DATA_W  equals rf_wdata
- wb_valid  out  1  stage holds a valid instruction
- misalign_err  out  1  valid MEM-sourced instruction with misaligned offset
- retired_cnt  out  CNT_W  committed-instruction count

## Operation

- Stage register update per rising edge, in priority order:
  - rst: clear all fields; valid=0.
  - flush_i: valid=0, regardless of stall_i. A held instruction is discarded without write or count.
  - stall_i: hold.
  - else: capture all in_* fields.
- Commit condition: commit = valid & !stall_i.
- Source select by registered wb_sel:
  - ALU: alu_result.
  - LINK: link_pc.
  - AUX: aux.
  - MEM: extracted load data.
- Load extraction for MEM:
  - Size bytes S = 1, 2, 4 or 8.
  - Lane = mem_rdata[(addr_lo*8) +: S*8].
  - Result is zero- or sign-extended to DATA_W per load_signed.
  - Full-width size ignores extension.
- Misalignment: addr_lo not a multiple of S, or dword with DATA_W=32. Then misalign_err=1 when valid, rf_wdata=0 and rf_wen=0. Not flagged for non-MEM sources.
- rf_wen = commit & reg_wen & (reg_addr != 0) & !misalign.
  - Register 0 is never written and never forwarded.
- rf_waddr = reg_addr; rf_wdata = selected value. Both are driven whenever valid, even with rf_wen low.
- Forwarding outputs are identical copies of the rf_* outputs.
- retired_cnt increments by 1 on each commit, including bubble-free no-write instructions and misaligned ones. Wraps modulo 2^CNT_W. Not cleared by flush.

## Timing

- Latency: in_* sampled at edge N appear on rf_*/fwd_* in cycle N+1; the output path after the register is combinational.
- One instruction per cycle throughput when stall_i=0.
- Reset values: wb_valid=0, rf_wen=0, fwd_valid=0, misalign_err=0, rf_waddr=0, rf_wdata=0, fwd_addr=0, fwd_data=0, retired_cnt=0.
- stall_i deasserted in cycle C with valid=1: the held instruction commits in C and is replaced at the C→C+1 edge.
- Stall held k cycles: a single commit (one write pulse, one count) in the first unstalled cycle.
- flush_i with in_valid=1: the incoming instruction is dropped.
- Reset during a stall or flush: reset wins; outputs return to reset values the next cycle.
- Counter wrap: all-ones + commit → 0, no flag.

## Test plan

- Reset, then ALU op (in_wb_sel=0, addr=8, alu=0x1234_5678): next cycle rf_wen=1, rf_waddr=8, rf_wdata=0x12345678, fwd mirrors it, retired_cnt=1.
- MEM byte loads with mem_rdata=0x80FF_7F01:
  - Signed, offset 3 → 0xFFFFFF80.
  - Unsigned, offset 1 → 0x0000007F.
  - Signed half, offset 2 → 0xFFFF80FF.
- Half load at offset 1: misalign_err=1, rf_wen=0, rf_wdata=0; retired_cnt still increments.
- Write to r0 (in_reg_addr=0, in_reg_wen=1, alu=0xDEAD): rf_wen=0, fwd_valid=0, counter +1.
- Instruction captured, then stall_i high for 3 cycles, then low: exactly one rf_wen pulse and one count, both in the first unstalled cycle. Repeat with flush_i asserted during the stall: no write and no count.
- CNT_W=4: 17 consecutive commits → retired_cnt=1 (wrap). Assert rst mid-stream → all outputs 0 the next cycle.
